// File: rtl/fft_reorder_sequencer.sv
// fft_reorder_sequencer
// Collects one frame of buffer_size signed samples, writing each at the bit-reversed
// address of its arrival index, then streams the frame out in natural address order.
// Output position k therefore carries input sample number bitrev(k).
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   abort       synchronous frame discard (FILL/DRAIN), overrides handshakes
//   in_valid    input sample valid
//   in_ready    block accepts a sample (FILL state)
//   in_sample   signed input sample
//   out_valid   output sample valid (DRAIN state)
//   out_ready   consumer accepts the output
//   out_sample  reordered sample, mem[rd_cnt]
//   out_index   output position within the frame
//   out_last    high with out_valid on the final position
//   frame_done  one-cycle pulse after the last output transfer
`timescale 1ns/1ps
module fft_reorder_sequencer #(
  parameter int unsigned buffer_size = 32,
  parameter int unsigned sample_size = 32,
  localparam int unsigned ADDR_W = $clog2(buffer_size)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [sample_size-1:0] in_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [sample_size-1:0] out_sample,
  output logic        [ADDR_W-1:0]      out_index,
  output logic                          out_last,
  output logic                          frame_done
);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(buffer_size - 1);

  state_e                        r_state, w_state_d;
  logic   [ADDR_W-1:0]           r_wr_cnt, w_wr_cnt_d;
  logic   [ADDR_W-1:0]           r_rd_cnt, w_rd_cnt_d;
  logic                          r_frame_done, w_frame_done_d;
  logic                          w_in_xfer, w_out_xfer;
  logic signed [sample_size-1:0] r_mem [buffer_size];

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < int'(ADDR_W); i++) begin
      r[i] = a[int'(ADDR_W) - 1 - i];
    end
    return r;
  endfunction

  // Handshake flags come from registered state only; abort cancels both transfers.
  assign in_ready   = (r_state == StFill);
  assign out_valid  = (r_state == StDrain);
  assign w_in_xfer  = in_ready & in_valid & ~abort;
  assign w_out_xfer = out_valid & out_ready & ~abort;

  assign out_sample = r_mem[r_rd_cnt];
  assign out_index  = r_rd_cnt;
  assign out_last   = out_valid & (r_rd_cnt == LastIdx);
  assign frame_done = r_frame_done;

  always_comb begin
    w_state_d      = r_state;
    w_wr_cnt_d     = r_wr_cnt;
    w_rd_cnt_d     = r_rd_cnt;
    w_frame_done_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_state_d = StFill;
      end
      StFill: begin
        if (abort) begin
          w_wr_cnt_d = '0;
          w_rd_cnt_d = '0;
        end else if (w_in_xfer) begin
          if (r_wr_cnt == LastIdx) begin
            w_state_d  = StDrain;
            w_wr_cnt_d = '0;
          end else begin
            w_wr_cnt_d = r_wr_cnt + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        if (abort) begin
          w_state_d  = StFill;
          w_wr_cnt_d = '0;
          w_rd_cnt_d = '0;
        end else if (w_out_xfer) begin
          if (r_rd_cnt == LastIdx) begin
            w_state_d      = StFill;
            w_rd_cnt_d     = '0;
            w_frame_done_d = 1'b1;
          end else begin
            w_rd_cnt_d = r_rd_cnt + ADDR_W'(1);
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_wr_cnt     <= w_wr_cnt_d;
      r_rd_cnt     <= w_rd_cnt_d;
      r_frame_done <= w_frame_done_d;
    end
  end

  // Sample storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_mem[bitrev(r_wr_cnt)] <= in_sample;
    end
  end

endmodule

// File: tb/tb_fft_reorder_sequencer.sv
`timescale 1ns/1ps
module tb_fft_reorder_sequencer;
  localparam int N  = 8;
  localparam int NB = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic signed [31:0] in_sample = '0;
  logic in_ready, out_valid, out_last, frame_done;
  logic signed [31:0] out_sample;
  logic [2:0] out_index;

  logic abort_b = 1'b0;
  logic in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic signed [31:0] in_sample_b = '0;
  logic in_ready_b, out_valid_b, out_last_b, frame_done_b;
  logic signed [31:0] out_sample_b;
  logic [4:0] out_index_b;

  always #5 clk = ~clk;

  fft_reorder_sequencer #(.buffer_size(N), .sample_size(32)) u_dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_index(out_index), .out_last(out_last), .frame_done(frame_done)
  );

  fft_reorder_sequencer #(.buffer_size(NB), .sample_size(32)) u_dut_b (
    .clk(clk), .rst(rst), .abort(abort_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sample(in_sample_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sample(out_sample_b),
    .out_index(out_index_b), .out_last(out_last_b), .frame_done(frame_done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) r = r | (((v >> i) & 1) << (w - 1 - i));
    return r;
  endfunction

  // Frame-level model: samples kept in arrival order, read back via bit reversal.
  int m_phase = 0;  // 0 idle, 1 collecting, 2 emitting
  int m_n = 0, m_k = 0, m_frames = 0;
  bit m_done = 1'b0;
  logic signed [31:0] m_buf [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_n = 0; m_k = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: m_phase = 1;
        1: begin
          if (abort) m_n = 0;
          else if (in_valid) begin
            m_buf[m_n] = in_sample;
            m_n++;
            if (m_n == N) begin m_phase = 2; m_k = 0; end
          end
        end
        default: begin
          if (abort) begin m_phase = 1; m_n = 0; m_k = 0; end
          else if (out_ready) begin
            if (m_k == N - 1) begin
              m_phase = 1; m_n = 0; m_k = 0; m_done = 1'b1; m_frames++;
            end else m_k++;
          end
        end
      endcase
    end
  end

  int dut_done = 0;
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_phase == 1);
    chk("out_valid", out_valid, m_phase == 2);
    chk("frame_done", frame_done, m_done);
    if (m_phase == 2) begin
      chk("out_sample", out_sample, m_buf[brev(m_k, 3)]);
      chk("out_index", out_index, m_k);
      chk("out_last", out_last, m_k == N - 1);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    if (rst) chk("out_index_rst", out_index, 0);
    if (frame_done) dut_done++;
  end

  logic signed [31:0] cap[$];
  logic signed [31:0] capb[$];
  int idx_b = 0;
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && !abort) cap.push_back(out_sample);
    if (!rst && out_valid_b && out_ready_b) capb.push_back(out_sample_b);
    if (!rst && in_valid_b && in_ready_b) idx_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frames(input int nf, input int pin, input int pout, input int base);
    int f0 = m_frames;
    int budget = 0;
    while (m_frames < f0 + nf && budget < 2000) begin
      in_valid  = ($urandom_range(99) < pin);
      out_ready = ($urandom_range(99) < pout);
      in_sample = base + m_n + 8 * (m_frames - f0);
      tick();
      budget++;
    end
    chk("frame_budget", m_frames >= f0 + nf, 1);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic fill_only(input int base);
    int budget = 0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    while (m_phase != 2 && budget < 100) begin
      in_sample = base + m_n;
      tick();
      budget++;
    end
    chk("fill_budget", m_phase, 2);
    in_valid = 1'b0;
  endtask

  task automatic chk_cap(input string name, input int base);
    int ord[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    chk({name, "_count"}, cap.size(), N);
    for (int i = 0; i < N && i < cap.size(); i++) chk(name, cap[i], base + ord[i]);
  endtask

  initial begin
    int budget;
    int done0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk("in_ready_before_edge", in_ready, 0);
    tick();
    chk("in_ready_after_edge", in_ready, 1);

    // Basic reorder, 100..107
    cap.delete();
    dut_done = 0;
    run_frames(1, 100, 100, 100);
    chk_cap("basic", 100);
    tick();
    chk("basic_done_pulses", dut_done, 1);

    // Signed data on the 32-deep instance
    in_valid_b = 1'b1;
    out_ready_b = 1'b1;
    budget = 0;
    in_sample_b = -16;
    while (capb.size() < NB && budget < 200) begin
      in_sample_b = -16 + idx_b;
      tick();
      budget++;
    end
    in_valid_b = 1'b0;
    out_ready_b = 1'b0;
    chk("signed_count", capb.size(), NB);
    for (int k = 0; k < NB && k < capb.size(); k++) chk("signed", capb[k], -16 + brev(k, 5));
    if (capb.size() >= NB) begin
      chk("signed_k1", capb[1], 0);
      chk("signed_k16", capb[16], -15);
      chk("signed_k31", capb[31], 15);
    end

    // Random backpressure, three frames
    dut_done = 0;
    run_frames(3, 50, 50, 1000);
    tick();
    chk("random_done_pulses", dut_done, 3);

    // Abort mid-fill on the 5th input
    in_valid = 1'b1;
    out_ready = 1'b1;
    budget = 0;
    while (m_n < 4 && budget < 50) begin
      in_sample = 50 + m_n;
      tick();
      budget++;
    end
    in_sample = 54;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cap.delete();
    run_frames(1, 100, 100, 0);
    chk_cap("abort_fill", 0);

    // Abort mid-drain at k=3
    fill_only(300);
    out_ready = 1'b1;
    budget = 0;
    while (m_k < 3 && budget < 50) begin tick(); budget++; end
    chk("drain_k3", m_k, 3);
    done0 = dut_done;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_drain_out_valid", out_valid, 0);
    chk("abort_drain_in_ready", in_ready, 1);
    chk("abort_drain_frame_done", frame_done, 0);
    tick();
    chk("abort_drain_no_pulse", dut_done, done0);
    cap.delete();
    run_frames(1, 100, 100, 200);
    chk_cap("after_abort", 200);

    // Async reset while draining
    fill_only(400);
    out_ready = 1'b1;
    budget = 0;
    while (m_k < 2 && budget < 50) begin tick(); budget++; end
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_index", out_index, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_in_ready_0", in_ready, 0);
    tick();
    chk("post_rst_in_ready_1", in_ready, 1);
    cap.delete();
    run_frames(1, 100, 100, 500);
    chk_cap("after_reset", 500);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_reorder_sequencer.md
# fft_reorder_sequencer

Streaming front end for the FFT datapath. Collects one frame of `buffer_size` serial samples, stores each at its bit-reversed address, then streams the frame back out in natural address order. The output is therefore the fully recursive even/odd decomposition that the butterfly stages consume. Valid/ready handshakes on both sides let it sit between the audio sample source and the FFT core.

## Interface
- `buffer_size`, default 32: samples per frame. Must be a power of two, ≥ 4.
- `sample_size`, default 32: bits per signed sample.
- `ADDR_W`: localparam equal to $clog2(buffer_size).
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `abort`  in  1  synchronous frame discard; see Operation.
- `in_valid`  in  1  `in_sample` is valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_sample`  in  sample_size  signed input sample.
- `out_valid`  out  1  `out_sample` is valid.
- `out_ready`  in  1  consumer accepts the output this cycle.
- `out_sample`  out  sample_size  signed reordered sample.
- `out_index`  out  ADDR_W  output position k within the frame, 0..buffer_size-1.
- `out_last`  out  1  high with `out_valid` when k = buffer_size-1.
- `frame_done`  out  1  one-cycle pulse after the last output transfer.

## Operation
- Storage is a register array `mem[0..buffer_size-1]`, `sample_size` bits per entry. It is not reset.
- Two counters, `wr_cnt` and `rd_cnt`, each ADDR_W bits.
- FSM states:
  - IDLE: reset state. Goes to FILL unconditionally on the next edge.
  - FILL: `in_ready`=1. On each input transfer (`in_valid` & `in_ready`), write `mem[bitrev(wr_cnt)] <= in_sample` and increment `wr_cnt`. The transfer made with `wr_cnt` = buffer_size-1 moves the FSM to DRAIN and clears `wr_cnt`.
  - DRAIN: `out_valid`=1. Outputs are `out_sample` = `mem[rd_cnt]`, `out_index` = `rd_cnt`, and `out_last` = (`rd_cnt` == buffer_size-1). On each output transfer (`out_valid` & `out_ready`), increment `rd_cnt`. The transfer with `out_last`=1 moves the FSM to FILL, clears `rd_cnt` and sets `frame_done` for one cycle.
- `bitrev` reverses all ADDR_W bits of the index. Output position k therefore carries input sample number bitrev(k).
- No width change: samples pass through bit-exact, with no arithmetic.
- FILL and DRAIN never overlap. `in_ready` and `out_valid` are never high in the same cycle.
- `abort` applies in FILL or DRAIN and has priority over every handshake in the same cycle:
  - The next state is FILL, `wr_cnt` and `rd_cnt` are cleared, and `frame_done` is not pulsed.
  - A sample presented in the abort cycle is dropped, even with `in_valid` & `in_ready` high.
  - An output presented in the abort cycle does not count as transferred.
- `abort` in IDLE has no effect.
- Backpressure:
  - `in_valid` low in FILL stalls `wr_cnt`.
  - `out_ready` low in DRAIN holds `out_sample`, `out_index` and `out_last` stable.

## Timing
- Reset values while `rst` is high: state=IDLE, `in_ready`=0, `out_valid`=0, `out_last`=0, `frame_done`=0, `out_index`=0, `wr_cnt`=0, `rd_cnt`=0. `out_sample` is don't-care.
- Reset release:
  - First rising edge moves IDLE to FILL.
  - `in_ready`=1 from the cycle after that edge.
- `in_ready`, `out_valid` and `frame_done` are decoded from registered state only. None depends combinationally on `in_valid` or `out_ready`.
- `out_sample` is a combinational read of `mem` indexed by the registered `rd_cnt`. It is don't-care when `out_valid`=0.
- Latency: the first output is valid on the cycle after the edge that captures the last input.
- Throughput with no stalls is one frame per 2·buffer_size cycles.
- DRAIN to FILL: `in_ready`=1 on the cycle after the final output transfer, coincident with `frame_done`=1.
- Reset mid-frame asynchronously forces the reset values. A partially filled frame is lost.

## Test plan
- Basic reorder, buffer_size=8, inputs 100..107 with `in_valid` held high and `out_ready`=1:
  - Outputs in order are 100,104,102,106,101,105,103,107, with `out_index` 0..7.
  - `out_last` is high only on 107; `frame_done` pulses once; `in_ready` returns the next cycle.
- Signed data, buffer_size=32, inputs −16..15:
  - Output k equals input bitrev5(k), sign preserved bit-exact.
  - Example: k=1 gives input index 16, value 0.
- Random backpressure, 3 back-to-back frames with `in_valid` and `out_ready` each toggled at 50% random:
  - Output sequences match the bitrev model; outputs are stable while `out_ready`=0.
  - `in_ready` and `out_valid` are never high together; `frame_done` pulses exactly 3 times.
- Abort mid-fill: abort asserted at the 5th input with `in_valid`=1, then a fresh frame 0..7:
  - Output is the bitrev order of the fresh frame only; the aborted sample is not stored.
- Abort mid-drain: abort asserted with `out_ready`=1 at k=3:
  - `out_valid`=0 the next cycle; no `frame_done` pulse; `in_ready`=1.
  - The next full frame reorders correctly.
- Async reset: `rst` asserted between clock edges in DRAIN:
  - All outputs take their reset values immediately.
  - `in_ready`=0 during reset and becomes 1 one cycle after the first post-release edge.
